uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one UART transmitter between `N` byte-stream requesters. It arbitrates round-robin, drives the transmitter's `din`/`tx_en` inputs and tracks its `tx_rdy` status. A grant is locked for a whole packet: bytes are sent until one is marked `last`. The block sits between the client logic and the transmit serializer.

## Interface

Parameters:
- `N`, 4: number of requesters (2..8).
- `LOCK_TIMEOUT`, 1024: clk cycles a locked owner may leave `req` low before the lock is force-released (≥2, fits 16 bits).

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in N: per-requester byte valid; held until `ack`.
- `din` in 8·N: byte of requester i on `din[8i+7:8i]`; stable while `req[i]` is high.
- `last` in N: marks the byte on `din[i]` as the final byte of a packet.
- `ack` out N: one-cycle pulse, byte of requester i accepted.
- `owner` out clog2(N): current or most recent grantee.
- `busy` out 1: high from grant until release.
- `lock_err` out 1: one-cycle pulse on a lock timeout.
- `tx_din` out 8: byte to the transmitter, held until the next accept.
- `tx_en` out 1: one-cycle start pulse to the transmitter.
- `tx_rdy` in 1: transmitter status; 1 = idle, 0 = transmitting.

## Operation

**Reset values:** while `rst_n`=0, all outputs are 0, state is IDLE, `locked`=0 and the round-robin pointer is N-1 (so requester 0 is served first). Reset mid-transfer aborts at once; no `ack` or `tx_en` is issued for the pending byte.

**Accept** means registering `owner`←i, `tx_din`←`din[i]`, `tx_en`←1, `ack[i]`←1 and `locked`←~`last[i]`, and loading the pointer with i.

States:
- **IDLE:** `busy`=0. If any `req` is set, accept the winner and go to WAIT_BUSY. The winner is the first set bit searching upward from pointer+1, modulo N.
- **WAIT_BUSY:** `busy`=1. Stay until `tx_rdy`=0, then go to WAIT_DONE. `req` is ignored.
- **WAIT_DONE:** Stay until `tx_rdy`=1. Then go to HOLD if `locked`, otherwise go to IDLE.
- **HOLD:** Other requesters are ignored.
  - If `req[owner]` is set: accept from `owner`, clear the timeout counter and go to WAIT_BUSY.
  - Otherwise increment the counter. When the counter reaches `LOCK_TIMEOUT`-1, pulse `lock_err`, clear `locked` and go to IDLE.

Rules:
- `tx_en` and `ack` are never high for more than one cycle, and never high outside an accept.
- `tx_din` is unchanged between accepts.
- Exactly one `ack` bit is high per accept.
- A requester that drops `req` before it receives `ack` gets no `ack`; no byte is lost or duplicated.
- All requests set in the same cycle are resolved by the pointer. Lower index wins only relative to the pointer position.
- If `last`=1 on the first byte, the packet is a single byte and the block returns to IDLE after it.

## Timing

- **Latency:** `req` first seen high at edge t (state IDLE or HOLD) → `tx_en`, `ack` and `tx_din` are valid in cycle t+1.
- **Requester handshake:** hold `req`, `din` and `last` through edge t. The requester may change them after seeing `ack`.
  - `req` still high in the `ack` cycle is not a second request, because the state is WAIT_BUSY.
- **Transmitter timing:** `tx_rdy` is expected to fall one clk after `tx_en`. The arbiter tolerates any longer delay.
- **Minimum spacing:** one transmitter frame plus 2 clk between consecutive `tx_en` pulses (the WAIT_DONE→HOLD/IDLE step plus the accept).
- **Timeout:** `lock_err` occurs exactly `LOCK_TIMEOUT` cycles after HOLD is entered with `req[owner]` continuously low.

## Test plan

1. **Reset:** hold `rst_n`=0 with `req`=4'b1111.
   - Required: all outputs 0.
   - After release: `ack`=4'b0001, `tx_din`=`din[0]`, `tx_en` a one-cycle pulse, exactly 1 clk after the first sampling edge.
2. **Round-robin:** `req`=4'b1111, all `last`=1; a transmitter model drops `tx_rdy` 1 clk after `tx_en` and restores it 10 clk later.
   - Required: grant order 0,1,2,3,0; one `tx_en` per byte; `busy` low for 1 cycle between bytes.
3. **Packet lock:** requester 2 sends 3 bytes (`last`=0,0,1; bytes 0xA1, 0xA2, 0xA3) while `req[1]` is held high.
   - Required: `tx_din` sequence A1, A2, A3, all with owner 2; then requester 1 is granted.
4. **Lock timeout:** `LOCK_TIMEOUT`=16; requester 0 sends a `last`=0 byte, then drops `req`; `req[3]` is high throughout.
   - Required: `lock_err` pulses exactly 16 cycles after HOLD entry; the next cycle is IDLE; requester 3 is accepted 1 cycle later.
5. **Reset mid-operation:** assert `rst_n`=0 during WAIT_DONE of a locked packet.
   - Required: outputs 0 immediately (asynchronously).
   - After release, the previous owner has no priority and requester 0 wins.
6. **Withdrawn request:** `req[1]` pulses for 1 cycle while the block is in WAIT_BUSY.
   - Required: no `ack[1]` and no `tx_en` for it.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter signal bundle for uart_tx_arbiter.
// The arbiter takes the slave side. The clients and the serializer take the master side.
interface uart_tx_arbiter_if #(parameter int N = 4);
  logic [N-1:0]         req;
  logic [8*N-1:0]       din;
  logic [N-1:0]         last;
  logic [N-1:0]         ack;
  logic [$clog2(N)-1:0] owner;
  logic                 busy;
  logic                 lock_err;
  logic [7:0]           tx_din;
  logic                 tx_en;
  logic                 tx_rdy;

  modport slave  (input  req, din, last, tx_rdy,
                  output ack, owner, busy, lock_err, tx_din, tx_en);
  modport master (output req, din, last, tx_rdy,
                  input  ack, owner, busy, lock_err, tx_din, tx_en);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N byte-stream clients.
// A grant stays locked to one client until that client sends a byte marked last.
module uart_tx_arbiter #(
  parameter int N            = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, HOLD} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [7:0]      tx_din_q, tx_din_d;
  logic            tx_en_q, tx_en_d;
  logic [N-1:0]    ack_q, ack_d;
  logic            locked_q, locked_d;
  logic            lock_err_q, lock_err_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic            acc;
  logic [IW-1:0]   acc_idx;

  // The search starts one past the last grantee, so the last grantee has the lowest priority.
  always_comb begin
    int j;
    win_vld = 1'b0;
    win_idx = '0;
    j       = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_q) + k) % N;
      if (!win_vld && bus.req[j]) begin
        win_vld = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    tx_din_d   = tx_din_q;
    tx_en_d    = 1'b0;
    ack_d      = '0;
    locked_d   = locked_q;
    lock_err_d = 1'b0;
    cnt_d      = '0;
    acc        = 1'b0;
    acc_idx    = '0;

    unique case (state_q)
      IDLE: if (win_vld) begin
        acc     = 1'b1;
        acc_idx = win_idx;
      end
      WAIT_BUSY: if (!bus.tx_rdy) state_d = WAIT_DONE;
      WAIT_DONE: if (bus.tx_rdy)  state_d = locked_q ? HOLD : IDLE;
      HOLD: begin
        if (bus.req[owner_q]) begin
          acc     = 1'b1;
          acc_idx = owner_q;
        end else if (cnt_q == 16'(LOCK_TIMEOUT - 1)) begin
          lock_err_d = 1'b1;
          locked_d   = 1'b0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (acc) begin
      owner_d          = acc_idx;
      ptr_d            = acc_idx;
      tx_din_d         = bus.din[{acc_idx, 3'b000} +: 8];
      tx_en_d          = 1'b1;
      ack_d[acc_idx]   = 1'b1;
      locked_d         = ~bus.last[acc_idx];
      state_d          = WAIT_BUSY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= IW'(N - 1);
      owner_q    <= '0;
      tx_din_q   <= '0;
      tx_en_q    <= 1'b0;
      ack_q      <= '0;
      locked_q   <= 1'b0;
      lock_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      tx_din_q   <= tx_din_d;
      tx_en_q    <= tx_en_d;
      ack_q      <= ack_d;
      locked_q   <= locked_d;
      lock_err_q <= lock_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.owner    = owner_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.lock_err = lock_err_q;
  assign bus.tx_din   = tx_din_q;
  assign bus.tx_en    = tx_en_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: N=4, LOCK_TIMEOUT=16. The transmitter model
// drops tx_rdy one clk after tx_en and raises it again 10 clk later.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N(4)) bus();

  uart_tx_arbiter #(.N(4), .LOCK_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int tx_cnt;

  always @(posedge clk or negedge rst_n)
    if (!rst_n)            tx_cnt <= 0;
    else if (bus.tx_en)    tx_cnt <= 10;
    else if (tx_cnt != 0)  tx_cnt <= tx_cnt - 1;
  assign bus.tx_rdy = (tx_cnt == 0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the next ack. Counts idle (busy=0) cycles and stray tx_en cycles seen before it.
  task automatic wait_ack(output int cyc, output int idle, output int en_early);
    cyc = 0; idle = 0; en_early = 0;
    do begin
      step();
      cyc++;
      if (bus.ack == '0) begin
        if (!bus.busy) idle++;
        if (bus.tx_en) en_early++;
      end
    end while (bus.ack == '0 && cyc < 60);
    if (bus.ack == '0) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 60) begin
      step();
      n++;
    end
    if (bus.busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int cyc, idle, en;
    int exp_own [4];
    int n, acks, ens;

    // Test 1: reset with all four requests pending
    bus.req  = 4'b1111;
    bus.last = 4'b1111;
    bus.din  = {8'h44, 8'h33, 8'h22, 8'h11};
    step(); step(); step();
    chk("rst_ack",      32'(bus.ack),      32'h0);
    chk("rst_owner",    32'(bus.owner),    32'h0);
    chk("rst_busy",     32'(bus.busy),     32'h0);
    chk("rst_lock_err", 32'(bus.lock_err), 32'h0);
    chk("rst_tx_din",   32'(bus.tx_din),   32'h0);
    chk("rst_tx_en",    32'(bus.tx_en),    32'h0);
    rst_n = 1'b1;
    step();
    chk("t1_ack",    32'(bus.ack),    32'h1);
    chk("t1_tx_din", 32'(bus.tx_din), 32'h11);
    chk("t1_tx_en",  32'(bus.tx_en),  32'h1);
    chk("t1_busy",   32'(bus.busy),   32'h1);

    // Test 2: round-robin. Each single-byte packet takes 13 clk from one accept to the next.
    exp_own = '{1, 2, 3, 0};
    for (int g = 0; g < 4; g++) begin
      wait_ack(cyc, idle, en);
      chk("rr_owner",   32'(bus.owner), 32'(exp_own[g]));
      chk("rr_ack",     32'(bus.ack),   32'(1 << exp_own[g]));
      chk("rr_tx_en",   32'(bus.tx_en), 32'h1);
      chk("rr_tx_din",  32'(bus.tx_din), 32'h11 * (exp_own[g] + 1));
      chk("rr_idle1",   32'(idle),      32'd1);
      chk("rr_en_once", 32'(en),        32'd0);
      chk("rr_spacing", 32'(cyc),       32'd13);
    end
    bus.req = 4'b0000;
    wait_idle();

    // Test 3: packet lock. Requester 1 waits behind requester 2's three-byte packet.
    bus.din[23:16] = 8'hA1; bus.last[2] = 1'b0; bus.req = 4'b0100;
    wait_ack(cyc, idle, en);
    chk("lk_own1", 32'(bus.owner), 32'd2);
    chk("lk_din1", 32'(bus.tx_din), 32'hA1);
    bus.req[1] = 1'b1; bus.last[1] = 1'b1; bus.din[15:8] = 8'h55;
    bus.din[23:16] = 8'hA2;
    wait_ack(cyc, idle, en);
    chk("lk_own2", 32'(bus.owner), 32'd2);
    chk("lk_ack2", 32'(bus.ack),   32'h4);
    chk("lk_din2", 32'(bus.tx_din), 32'hA2);
    bus.din[23:16] = 8'hA3; bus.last[2] = 1'b1;
    wait_ack(cyc, idle, en);
    chk("lk_own3", 32'(bus.owner), 32'd2);
    chk("lk_din3", 32'(bus.tx_din), 32'hA3);
    bus.req[2] = 1'b0;
    wait_ack(cyc, idle, en);
    chk("lk_next_own", 32'(bus.owner), 32'd1);
    chk("lk_next_din", 32'(bus.tx_din), 32'h55);
    bus.req = 4'b0000;
    wait_idle();

    // Test 4: lock timeout. HOLD is entered 12 clk after the ack, and lock_err fires 16 clk after that.
    bus.din[7:0] = 8'hB0; bus.last[0] = 1'b0; bus.req = 4'b0001;
    wait_ack(cyc, idle, en);
    chk("to_own", 32'(bus.owner), 32'd0);
    bus.req = 4'b1000; bus.last[3] = 1'b1; bus.din[31:24] = 8'hC3;
    n = 0; acks = 0;
    do begin
      step();
      n++;
      if (bus.ack != '0) acks++;
    end while (!bus.lock_err && n < 60);
    chk("to_lat",  32'(n),        32'd28);
    chk("to_noack", 32'(acks),    32'd0);
    chk("to_idle", 32'(bus.busy), 32'd0);
    step();
    chk("to_err_pulse", 32'(bus.lock_err), 32'd0);
    chk("to_ack3",      32'(bus.ack),      32'h8);
    chk("to_din3",      32'(bus.tx_din),   32'hC3);

    // Test 6: a one-cycle req[1] pulse during WAIT_BUSY is ignored
    bus.req = 4'b0010;
    step();
    bus.req = 4'b0000;
    acks = 0; ens = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.ack != '0) acks++;
      if (bus.tx_en) ens++;
    end
    chk("wd_ack",   32'(acks),     32'd0);
    chk("wd_tx_en", 32'(ens),      32'd0);
    chk("wd_busy",  32'(bus.busy), 32'd0);

    // Test 5: asynchronous reset during WAIT_DONE of a locked packet
    bus.din[23:16] = 8'hD2; bus.last[2] = 1'b0; bus.last[0] = 1'b1;
    bus.req = 4'b0100;
    wait_ack(cyc, idle, en);
    chk("mr_own", 32'(bus.owner), 32'd2);
    for (int i = 0; i < 5; i++) step();
    chk("mr_busy_pre", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy",   32'(bus.busy),   32'd0);
    chk("mr_owner",  32'(bus.owner),  32'd0);
    chk("mr_tx_din", 32'(bus.tx_din), 32'd0);
    chk("mr_ack",    32'(bus.ack),    32'd0);
    chk("mr_tx_en",  32'(bus.tx_en),  32'd0);
    bus.req = 4'b0101;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("mr_ack0",  32'(bus.ack),    32'h1);
    chk("mr_din0",  32'(bus.tx_din), 32'hB0);
    bus.req = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
